// File: rtl/ram_part_reinit.sv
// Multi-ported RAM split into power-gated partitions. A hardware walker
// initialises the whole array after reset and re-initialises each partition
// when it is powered back on. While the walker runs, ramReady_o is low and
// user writes are dropped.
// Optional build macro: RAM_WR_BYPASS_EN (same-cycle write-to-read forwarding).
module ram_part_reinit #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned INDEX        = 6,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_RD_PORTS = 4,
  parameter int unsigned NUM_WR_PORTS = 2,
  parameter int unsigned NUM_PARTS    = 4,
  parameter int unsigned RESET_VAL    = 0,
  parameter int unsigned SEQ_START    = 0,
  localparam int unsigned PBITS       = $clog2(NUM_PARTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PARTS-1:0]            partitionGated_i,
  input  logic [NUM_WR_PORTS-1:0]         writePortGated_i,
  input  logic [NUM_RD_PORTS-1:0]         readPortGated_i,
  input  logic [NUM_RD_PORTS*INDEX-1:0]   addr_i,
  output logic [NUM_RD_PORTS*WIDTH-1:0]   data_o,
  input  logic [NUM_WR_PORTS*INDEX-1:0]   addrWr_i,
  input  logic [NUM_WR_PORTS*WIDTH-1:0]   dataWr_i,
  input  logic [NUM_WR_PORTS-1:0]         wrEn_i,
  output logic                            ramReady_o,
  output logic [PBITS-1:0]                initPart_o
);

  localparam int unsigned OFFS = INDEX - PBITS;

`ifdef RAM_WR_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef enum logic [1:0] {StFullInit, StReady, StPartInit} state_e;

  state_e               state_q;
  logic [INDEX-1:0]     ptr_q;
  logic [NUM_PARTS-1:0] pending_q;
  logic [NUM_PARTS-1:0] gated_q;
  logic                 ready_q;
  logic [PBITS-1:0]     init_part_q;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic [NUM_PARTS-1:0]    gate_eff;
  logic [NUM_PARTS-1:0]    fell;
  logic [NUM_PARTS-1:0]    pend_live;
  logic [NUM_PARTS-1:0]    pend_next;
  logic [PBITS-1:0]        first_part;
  logic [PBITS-1:0]        next_part;
  logic                    part_done;
  logic                    part_abort;
  logic [WIDTH-1:0]        init_val;
  logic [NUM_WR_PORTS-1:0] wr_acc;
  logic [WIDTH-1:0]        rd_word;

  function automatic logic [PBITS-1:0] part_of(input logic [INDEX-1:0] a);
    return a[INDEX-1 -: PBITS];
  endfunction

  function automatic logic [PBITS-1:0] lowest_set(input logic [NUM_PARTS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_PARTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = PBITS'(i);
    end
  endfunction

  // Gate bookkeeping and walker control decode.
  always_comb begin
    gate_eff    = partitionGated_i;
    gate_eff[0] = 1'b0;  // partition 0 can never be powered off
    fell        = gated_q & ~gate_eff;
    // Re-gating a partition silently cancels its pending re-init.
    pend_live   = pending_q & ~gate_eff;
    pend_next   = pend_live;
    pend_next[init_part_q] = 1'b0;
    first_part  = lowest_set(pend_live);
    next_part   = lowest_set(pend_next);
    part_abort  = gate_eff[init_part_q];
    part_done   = (ptr_q == {init_part_q, {OFFS{1'b1}}});
    init_val    = (RESET_VAL == 1) ? WIDTH'(SEQ_START + 32'(ptr_q)) : '0;
  end

  // Write acceptance per port: ready, enabled, port on, target partition on.
  always_comb begin
    wr_acc = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      wr_acc[w] = ready_q && wrEn_i[w] && !writePortGated_i[w] &&
                  !gate_eff[part_of(addrWr_i[w*INDEX +: INDEX])];
    end
  end

  // Init FSM: full walk after reset, per-partition walks on power-up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StFullInit;
      ptr_q       <= '0;
      pending_q   <= '0;
      gated_q     <= gate_eff;
      ready_q     <= 1'b0;
      init_part_q <= '0;
    end else begin
      gated_q <= gate_eff;
      case (state_q)
        StFullInit: begin
          pending_q <= '0;  // the full walk already covers every partition
          if (ptr_q == INDEX'(DEPTH - 1)) begin
            state_q <= StReady;
            ready_q <= 1'b1;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        StReady: begin
          pending_q <= pend_live | fell;
          if (|pend_live) begin
            state_q     <= StPartInit;
            ready_q     <= 1'b0;
            init_part_q <= first_part;
            ptr_q       <= {first_part, {OFFS{1'b0}}};
          end
        end
        StPartInit: begin
          if (part_done || part_abort) begin
            pending_q <= pend_next | fell;
            if (|pend_next) begin
              // Chain straight into the next partition, ready stays low.
              init_part_q <= next_part;
              ptr_q       <= {next_part, {OFFS{1'b0}}};
            end else begin
              state_q     <= StReady;
              ready_q     <= 1'b1;
              init_part_q <= '0;
              ptr_q       <= '0;
            end
          end else begin
            pending_q <= pend_live | fell;
            ptr_q     <= ptr_q + 1'b1;
          end
        end
        default: state_q <= StFullInit;
      endcase
    end
  end

  // Array update: walker owns the array while not ready, users otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q != StReady) mem[ptr_q] <= init_val;
      // Ascending order lets the highest-numbered port win a collision.
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_acc[w]) mem[addrWr_i[w*INDEX +: INDEX]] <= dataWr_i[w*WIDTH +: WIDTH];
      end
    end
  end

  // Combinational reads with optional forwarding and gating to zero.
  always_comb begin
    data_o  = '0;
    rd_word = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      rd_word = mem[addr_i[r*INDEX +: INDEX]];
      if (Bypass) begin
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          if (wr_acc[w] && addrWr_i[w*INDEX +: INDEX] == addr_i[r*INDEX +: INDEX]) begin
            rd_word = dataWr_i[w*WIDTH +: WIDTH];
          end
        end
      end
      if (!readPortGated_i[r] && !gate_eff[part_of(addr_i[r*INDEX +: INDEX])]) begin
        data_o[r*WIDTH +: WIDTH] = rd_word;
      end
    end
  end

  assign ramReady_o = ready_q;
  assign initPart_o = init_part_q;

endmodule

// File: tb/tb_ram_part_reinit.sv
module tb_ram_part_reinit;

  localparam int RV  = 1;
  localparam int SEQ = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   partitionGated_i;
  logic [1:0]   writePortGated_i;
  logic [3:0]   readPortGated_i;
  logic [23:0]  addr_i;
  logic [127:0] data_o;
  logic [11:0]  addrWr_i;
  logic [63:0]  dataWr_i;
  logic [1:0]   wrEn_i;
  logic         ramReady_o;
  logic [1:0]   initPart_o;

  ram_part_reinit #(
    .DEPTH(64), .INDEX(6), .WIDTH(32), .NUM_RD_PORTS(4), .NUM_WR_PORTS(2),
    .NUM_PARTS(4), .RESET_VAL(RV), .SEQ_START(SEQ)
  ) dut (
    .clk(clk), .reset(reset), .partitionGated_i(partitionGated_i),
    .writePortGated_i(writePortGated_i), .readPortGated_i(readPortGated_i),
    .addr_i(addr_i), .data_o(data_o), .addrWr_i(addrWr_i), .dataWr_i(dataWr_i),
    .wrEn_i(wrEn_i), .ramReady_o(ramReady_o), .initPart_o(initPart_o)
  );

  always #5 clk = ~clk;

  // kind: 0 read port data, 1 ready flag, 2 initPart, 3 measured value in act
  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] exp;
    logic [31:0] act;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_m [64];

  function automatic logic [31:0] pat(input int k);
    return (RV == 1) ? 32'(SEQ + k) : 32'h0;
  endfunction

  function automatic bit mgated(input logic [5:0] a);
    return (a[5:4] != 2'd0) && partitionGated_i[a[5:4]];
  endfunction

  task automatic push(input int kind, input int idx, input logic [31:0] exp,
                      input logic [31:0] act, input string nm);
    exp_t e;
    e.kind = kind; e.idx = idx; e.exp = exp; e.act = act; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = data_o[e.idx*32 +: 32];
        1:       act = 32'(ramReady_o);
        2:       act = 32'(initPart_o);
        default: act = e.act;
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
      end
    end
  end

  task automatic idle();
    wrEn_i = '0; writePortGated_i = '0; readPortGated_i = '0;
    partitionGated_i[0] = 1'b0;
  endtask

  task automatic chk_read(input int r, input int a, input logic [31:0] exp,
                          input string nm);
    addr_i[r*6 +: 6] = 6'(a);
    readPortGated_i[r] = 1'b0;
    push(0, r, exp, 0, nm);
  endtask

  // Reset, then count cycles until ready; optionally wiggle gate 3 meanwhile.
  task automatic do_reset(input bit toggle3);
    int cycles;
    idle();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    push(1, 0, 0, 0, "ready_after_reset");
    push(2, 0, 0, 0, "initpart_after_reset");
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (toggle3 && cycles == 10) partitionGated_i[3] = 1'b1;
      if (toggle3 && cycles == 20) partitionGated_i[3] = 1'b0;
      if (ramReady_o) break;
    end
    push(3, 0, 64, cycles, "full_init_cycles");
    for (int k = 0; k < 64; k++) mem_m[k] = pat(k);
    for (int i = 0; i < 20; i++) begin
      push(1, 0, 1, 0, "ready_holds_after_init");
      @(posedge clk); #1;
    end
  endtask

  // Count negedges with ready low; try a write during the low window.
  task automatic measure_low(input logic [3:0] regate, output int lows,
                             output logic [1:0] ip1, output logic [1:0] ip17);
    int guard;
    lows = 0; guard = 0; ip1 = '0; ip17 = '0;
    while (guard < 300) begin
      @(negedge clk);
      guard++;
      if (!ramReady_o) begin
        lows++;
        if (lows == 1) begin
          ip1 = initPart_o;
          wrEn_i = 2'b01; addrWr_i[5:0] = 6'd10; dataWr_i[31:0] = 32'hDEAD_0000;
        end
        if (lows == 3) partitionGated_i = partitionGated_i | regate;
        if (lows == 17) ip17 = initPart_o;
      end else if (lows > 0) begin
        break;
      end else if (guard > 10) begin
        break;
      end
    end
    wrEn_i = '0;
  endtask

  task automatic reinit(input logic [3:0] clear, input logic [3:0] regate,
                        input int exp_low, input int exp_ip1, input int exp_ip17);
    int         lows;
    logic [1:0] ip1, ip17;
    logic [3:0] done;
    partitionGated_i = partitionGated_i & ~clear;
    partitionGated_i[0] = 1'b0;
    measure_low(regate, lows, ip1, ip17);
    push(3, 0, 32'(exp_low), 32'(lows), "reinit_low_cycles");
    push(3, 0, 32'(exp_ip1), 32'(ip1), "init_part_first");
    if (exp_low > 16) push(3, 0, 32'(exp_ip17), 32'(ip17), "init_part_second");
    done = clear & ~regate;
    for (int k = 0; k < 64; k++) if (done[k/16]) mem_m[k] = pat(k);
    @(posedge clk); #1;
  endtask

  task automatic rand_cycle(input logic [3:0] hold);
    logic [5:0]  wa [2];
    logic [31:0] wd [2];
    bit          acc [2];
    logic [5:0]  a;
    logic [31:0] exp;
    partitionGated_i = {hold[3:1], 1'($urandom_range(0, 1))};
    wrEn_i = 2'($urandom);
    writePortGated_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
    for (int w = 0; w < 2; w++) begin
      wa[w] = 6'($urandom); wd[w] = $urandom;
    end
    if ($urandom_range(0, 3) == 0) wa[1] = wa[0];
    for (int w = 0; w < 2; w++) begin
      addrWr_i[w*6 +: 6] = wa[w]; dataWr_i[w*32 +: 32] = wd[w];
      acc[w] = wrEn_i[w] && !writePortGated_i[w] && !mgated(wa[w]);
    end
    readPortGated_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
    for (int r = 0; r < 4; r++) begin
      a = ($urandom_range(0, 1) == 1) ? wa[$urandom_range(0, 1)] : 6'($urandom);
      addr_i[r*6 +: 6] = a;
      exp = mem_m[a];
`ifdef RAM_WR_BYPASS_EN
      for (int w = 0; w < 2; w++) if (acc[w] && wa[w] == a) exp = wd[w];
`endif
      if (readPortGated_i[r] || mgated(a)) exp = 32'h0;
      push(0, r, exp, 0, "rand_read");
    end
    push(1, 0, 1, 0, "rand_ready");
    @(posedge clk);
    for (int w = 0; w < 2; w++) if (acc[w]) mem_m[wa[w]] = wd[w];
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; partitionGated_i = '0; writePortGated_i = '0; readPortGated_i = '0;
    addr_i = '0; addrWr_i = '0; dataWr_i = '0; wrEn_i = '0;
    @(posedge clk); #1;

    // Full init with sequential pattern.
    do_reset(1'b0);
    chk_read(0, 5, 32'd21, "seq_addr5");
    addr_i[11:6] = 6'd5; readPortGated_i[1] = 1'b1;
    push(0, 1, 32'h0, 0, "read_port_gated");
    @(posedge clk); #1;
    idle();

    // Two ports to one address: port 1 wins.
    wrEn_i = 2'b11;
    addrWr_i = {6'd3, 6'd3};
    dataWr_i = {32'h0000_5555, 32'h0000_AAAA};
    @(posedge clk); #1;
    wrEn_i = '0; mem_m[3] = 32'h5555;
    chk_read(2, 3, 32'h5555, "write_priority");
    @(posedge clk); #1;

    // Same-cycle write and read.
    wrEn_i = 2'b01; addrWr_i[5:0] = 6'd7; dataWr_i[31:0] = 32'hBEEF;
`ifdef RAM_WR_BYPASS_EN
    chk_read(0, 7, 32'hBEEF, "same_cycle_read");
`else
    chk_read(0, 7, mem_m[7], "same_cycle_read");
`endif
    @(posedge clk); #1;
    wrEn_i = '0; mem_m[7] = 32'hBEEF;
    chk_read(0, 7, 32'hBEEF, "after_write_7");
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) rand_cycle(4'b0000);
    idle();
    for (int i = 0; i < 80; i++) rand_cycle(4'b0100);
    idle();

    // Write into gated partition is dropped; partition 0 write lands.
    wrEn_i = 2'b11;
    addrWr_i = {6'd10, 6'd40};
    dataWr_i = {32'hCAFE_0010, 32'h0000_1234};
    chk_read(0, 40, 32'h0, "gated_read_40");
    @(posedge clk); #1;
    wrEn_i = '0; mem_m[10] = 32'hCAFE_0010;
    chk_read(0, 40, 32'h0, "gated_read_40_after");
    @(posedge clk); #1;
    reinit(4'b0100, 4'b0000, 16, 2, 0);
    chk_read(0, 40, pat(40), "reinit_addr40");
    chk_read(1, 10, 32'hCAFE_0010, "keep_addr10");
    @(posedge clk); #1;

    // Two partitions ungated together, then with one re-gated mid-init.
    partitionGated_i = 4'b1010;
    @(posedge clk); #1; @(posedge clk); #1;
    reinit(4'b1010, 4'b0000, 32, 1, 3);
    chk_read(0, 20, pat(20), "reinit_p1");
    chk_read(1, 50, pat(50), "reinit_p3");
    @(posedge clk); #1;
    partitionGated_i = 4'b1010;
    @(posedge clk); #1; @(posedge clk); #1;
    reinit(4'b1010, 4'b1000, 16, 1, 0);
    chk_read(0, 50, 32'h0, "regated_p3_reads0");
    chk_read(1, 17, pat(17), "reinit_p1_again");
    @(posedge clk); #1;
    reinit(4'b1000, 4'b0000, 16, 3, 0);
    chk_read(0, 63, pat(63), "reinit_p3_last");
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) rand_cycle(4'b0000);
    idle();

    // Reset during a partition init.
    partitionGated_i[2] = 1'b1;
    @(posedge clk); #1;
    partitionGated_i[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    push(1, 0, 0, 0, "ready_in_part_init");
    push(2, 0, 2, 0, "initpart_in_part_init");
    do_reset(1'b1);
    chk_read(0, 5, 32'd21, "seq_addr5_after_reset");
    chk_read(3, 40, pat(40), "seq_addr40_after_reset");
    @(negedge clk);
    @(posedge clk); #1;

    if (ramReady_o !== 1'b1) begin
      n_err++;
      $display("FAIL final_ready: got %0h, expected 1", ramReady_o);
    end
    if (data_o[31:0] !== pat(5)) begin
      n_err++;
      $display("FAIL final_addr5: got %0h, expected %0h", data_o[31:0], pat(5));
    end
    if (data_o[127:96] !== pat(40)) begin
      n_err++;
      $display("FAIL final_addr40: got %0h, expected %0h", data_o[127:96], pat(40));
    end
    if (initPart_o !== 2'd0) begin
      n_err++;
      $display("FAIL final_initpart: got %0h, expected 0", initPart_o);
    end
    if (n_vec <= 0) begin
      n_err++;
      $display("FAIL vector_count: got %0d, expected nonzero", n_vec);
    end

    @(negedge clk); @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
